// File: rtl/uart_pkg.sv
// Shared types and constants for the parametrised UART receiver.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      BRK
   } rx_state_t;

   localparam int unsigned MIN_BAUD_DIV = 4;

   // Divisors below the minimum cannot place a sample at the bit centre.
   function automatic int unsigned clamp_div(input int unsigned div);
      return (div < MIN_BAUD_DIV) ? MIN_BAUD_DIV : div;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO: the head entry is presented combinationally from storage.
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = rd_en && !empty;
   // A pop in the same cycle frees the slot a full FIFO would otherwise refuse.
   assign do_push = wr_en && (!full || do_pop);
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= wr_data;
            wr_ptr      <= wr_ptr + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/uart_rx_ext.sv
// UART receiver with runtime baud divisor, optional parity, break handling and a FWFT receive FIFO.
module uart_rx_ext
   import uart_pkg::*;
#(
   parameter int unsigned DATA_W     = 8,
   parameter int unsigned BAUD_W     = 16,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          RX,
   input  logic [BAUD_W-1:0]             baud_div,
   input  logic                          parity_en,
   input  logic                          parity_odd,
   input  logic                          rd_en,
   input  logic                          clr_ovr,
   output logic [DATA_W-1:0]             rx_data,
   output logic                          par_err,
   output logic                          frm_err,
   output logic                          rdy,
   output logic                          overrun,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt
);

   localparam int unsigned BC_W = $clog2(DATA_W);

   // Width follows DATA_W, so the entry layout lives here rather than in uart_pkg.
   typedef struct packed {
      logic              par_err;
      logic              frm_err;
      logic [DATA_W-1:0] data;
   } rx_entry_t;

   rx_state_t         state;
   rx_state_t         state_nxt;
   logic              rx_meta;
   logic              rx_sync;
   logic [BAUD_W-1:0] div_in;
   logic [BAUD_W-1:0] div_q;
   logic [BAUD_W-1:0] baud_cnt;
   logic              par_en_q;
   logic              par_odd_q;
   logic [BC_W-1:0]   bit_cnt;
   logic [DATA_W-1:0] shreg;
   logic              par_err_q;
   logic              start_det;
   logic              sample;
   logic              last_bit;
   logic              push;
   logic              drop;
   logic              fifo_full;
   logic              fifo_empty;
   rx_entry_t         wr_entry;
   rx_entry_t         rd_entry;

   assign div_in   = BAUD_W'(clamp_div(32'(baud_div)));
   assign last_bit = (bit_cnt == BC_W'(DATA_W - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
      end else begin
         rx_meta <= RX;
         rx_sync <= rx_meta;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (!rx_sync) state_nxt = START;
         START:   if (sample) state_nxt = rx_sync ? IDLE : DATA;
         DATA:    if (sample && last_bit) state_nxt = par_en_q ? PARITY : STOP;
         PARITY:  if (sample) state_nxt = STOP;
         STOP:    if (sample) state_nxt = rx_sync ? IDLE : BRK;
         BRK:     if (rx_sync) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      start_det = 1'b0;
      sample    = 1'b0;
      push      = 1'b0;
      if (state == IDLE) begin
         start_det = !rx_sync;
      end
      if (state inside {START, DATA, PARITY, STOP}) begin
         sample = (baud_cnt == '0);
      end
      push = (state == STOP) && sample;
   end

   // Half-period preload puts every sample at a bit centre; later reloads keep full periods.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_q     <= '0;
         baud_cnt  <= '0;
         par_en_q  <= 1'b0;
         par_odd_q <= 1'b0;
         bit_cnt   <= '0;
         shreg     <= '0;
         par_err_q <= 1'b0;
      end else begin
         if (start_det) begin
            div_q     <= div_in;
            par_en_q  <= parity_en;
            par_odd_q <= parity_odd;
            baud_cnt  <= (div_in >> 1) - BAUD_W'(1);
            bit_cnt   <= '0;
            par_err_q <= 1'b0;
         end else if (sample) begin
            baud_cnt <= div_q - BAUD_W'(1);
         end else if (state != IDLE && state != BRK) begin
            baud_cnt <= baud_cnt - BAUD_W'(1);
         end
         if (sample && state == DATA) begin
            shreg   <= {rx_sync, shreg[DATA_W-1:1]};
            bit_cnt <= bit_cnt + BC_W'(1);
         end
         if (sample && state == PARITY) begin
            par_err_q <= ((^shreg) ^ rx_sync) != par_odd_q;
         end
      end
   end

   always_comb begin
      wr_entry.par_err = par_err_q;
      wr_entry.frm_err = ~rx_sync;
      wr_entry.data    = shreg;
   end

   sync_fifo #(
      .WIDTH ($bits(rx_entry_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (push),
      .wr_data (wr_entry),
      .rd_en   (rd_en),
      .rd_data (rd_entry),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_cnt)
   );

   assign drop = push && fifo_full && !rd_en;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overrun <= 1'b0;
      end else if (drop) begin
         overrun <= 1'b1;
      end else if (clr_ovr) begin
         overrun <= 1'b0;
      end
   end

   assign rdy     = !fifo_empty;
   assign rx_data = rd_entry.data;
   assign par_err = rd_entry.par_err;
   assign frm_err = rd_entry.frm_err;

endmodule

// File: tb/tb_uart_rx_ext.sv
// Self-checking bench for uart_rx_ext: serial frames are driven on RX and the FIFO is compared to a queue model.
module tb_uart_rx_ext;

   localparam int unsigned DATA_W     = 8;
   localparam int unsigned BAUD_W     = 16;
   localparam int unsigned FIFO_DEPTH = 4;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b1;
   logic                 RX = 1'b1;
   logic [BAUD_W-1:0]    baud_div = 16;
   logic                 parity_en = 1'b0;
   logic                 parity_odd = 1'b0;
   logic                 rd_en = 1'b0;
   logic                 clr_ovr = 1'b0;
   logic [DATA_W-1:0]    rx_data;
   logic                 par_err;
   logic                 frm_err;
   logic                 rdy;
   logic                 overrun;
   logic [2:0]           fifo_cnt;

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct {
      logic [DATA_W-1:0] data;
      logic              par_err;
      logic              frm_err;
   } exp_t;

   exp_t model_q[$];
   logic ovr_exp = 1'b0;

   uart_rx_ext #(
      .DATA_W     (DATA_W),
      .BAUD_W     (BAUD_W),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .RX         (RX),
      .baud_div   (baud_div),
      .parity_en  (parity_en),
      .parity_odd (parity_odd),
      .rd_en      (rd_en),
      .clr_ovr    (clr_ovr),
      .rx_data    (rx_data),
      .par_err    (par_err),
      .frm_err    (frm_err),
      .rdy        (rdy),
      .overrun    (overrun),
      .fifo_cnt   (fifo_cnt)
   );

   always #5 clk = ~clk;

   function automatic exp_t model_entry(input logic [DATA_W-1:0] d, input bit pen, input bit podd,
                                        input bit pbit, input bit stopb);
      exp_t e;
      int   ones;
      ones      = $countones(d) + ((pen && pbit) ? 1 : 0);
      e.data    = d;
      e.par_err = pen && ((ones % 2) != (podd ? 1 : 0));
      e.frm_err = !stopb;
      return e;
   endfunction

   // Receiver-side push of a completed frame, including the overflow rule.
   function automatic void model_push(input exp_t e, input bit pop_same_cycle);
      if (pop_same_cycle && model_q.size() != 0) void'(model_q.pop_front());
      if (model_q.size() < FIFO_DEPTH) model_q.push_back(e);
      else ovr_exp = 1'b1;
   endfunction

   function automatic int unsigned eff_div(input int unsigned d);
      return (d < 4) ? 4 : d;
   endfunction

   // Synced stop-bit centre lands two clocks after the pin centre; that edge is the push.
   function automatic int push_edge(input int unsigned div, input bit pen);
      return int'(div / 2 + div * (DATA_W + 1 + (pen ? 1 : 0))) + 2;
   endfunction

   // Call at a negedge; drives one frame with div clks per bit, optional rd_en pulse at index pop_at.
   task automatic send_frame(input logic [DATA_W-1:0] d, input bit pen, input bit pbit, input bit stopb,
                             input int unsigned div, input int pop_at, output int first_rdy);
      logic [11:0] bits;
      int          nbits;
      nbits     = DATA_W + 2 + (pen ? 1 : 0);
      bits      = '1;
      bits[0]   = 1'b0;
      for (int i = 0; i < DATA_W; i++) bits[1+i] = d[i];
      if (pen) bits[DATA_W+1] = pbit;
      bits[nbits-1] = stopb;
      first_rdy = -1;
      for (int k = 0; k < nbits * int'(div); k++) begin
         RX    = bits[k / int'(div)];
         rd_en = (k == pop_at);
         @(negedge clk);
         if (first_rdy < 0 && rdy) first_rdy = k + 1;
      end
      rd_en = 1'b0;
   endtask

   task automatic idle(input int n);
      RX = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   task automatic pop_head(output logic [DATA_W-1:0] d, output logic pe, output logic fe);
      d     = rx_data;
      pe    = par_err;
      fe    = frm_err;
      rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
   endtask

   task automatic test_reset();
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++; if ({rdy, overrun, fifo_cnt} !== 5'b0) $display("FAIL reset_flags: got rdy=%b ovr=%b cnt=%0d required 0/0/0", rdy, overrun, fifo_cnt); else n_pass++;
      n_checks++; if ({rx_data, par_err, frm_err} !== '0) $display("FAIL reset_data: got %h/%b/%b required 0", rx_data, par_err, frm_err); else n_pass++;
      rst_n = 1'b1;
      idle(4);
   endtask

   task automatic test_8n1();
      int          fr;
      exp_t        e;
      logic [DATA_W-1:0] d;
      logic        pe, fe;
      baud_div = 16; parity_en = 0;
      e = model_entry(8'hA5, 0, 0, 0, 1);
      send_frame(8'hA5, 0, 0, 1, 16, -1, fr);
      model_push(e, 0);
      idle(8);
      n_checks++; if (fr !== push_edge(16, 0) + 1) $display("FAIL t1_rdy_latency: got %0d required %0d", fr, push_edge(16, 0) + 1); else n_pass++;
      n_checks++; if (fifo_cnt !== 3'(model_q.size())) $display("FAIL t1_cnt: got %0d required %0d", fifo_cnt, model_q.size()); else n_pass++;
      pop_head(d, pe, fe);
      e = model_q.pop_front();
      n_checks++; if ({d, pe, fe} !== {e.data, e.par_err, e.frm_err}) $display("FAIL t1_entry: got %h/%b/%b required %h/%b/%b", d, pe, fe, e.data, e.par_err, e.frm_err); else n_pass++;
      n_checks++; if (rdy !== 1'b0) $display("FAIL t1_rdy_after_pop: got %b required 0", rdy); else n_pass++;
   endtask

   task automatic test_parity();
      int   fr;
      exp_t e;
      logic [DATA_W-1:0] d;
      logic pe, fe;
      parity_en = 1; parity_odd = 0;
      for (int i = 0; i < 2; i++) begin
         send_frame(8'h03, 1, i[0], 1, 16, -1, fr);
         model_push(model_entry(8'h03, 1, 0, i[0], 1), 0);
         idle(8);
      end
      for (int i = 0; i < 2; i++) begin
         pop_head(d, pe, fe);
         e = model_q.pop_front();
         n_checks++; if ({d, pe, fe} !== {e.data, e.par_err, e.frm_err}) $display("FAIL t2_parity_%0d: got %h/%b/%b required %h/%b/%b", i, d, pe, fe, e.data, e.par_err, e.frm_err); else n_pass++;
      end
      parity_en = 0;
   endtask

   task automatic test_glitch_framing();
      int   fr;
      exp_t e;
      logic [DATA_W-1:0] d;
      logic pe, fe;
      RX = 1'b0;
      repeat (6) @(negedge clk);
      idle(40);
      n_checks++; if (fifo_cnt !== 3'(model_q.size())) $display("FAIL t3_glitch_cnt: got %0d required %0d", fifo_cnt, model_q.size()); else n_pass++;
      // Line held low well past a whole frame time: a break, not a stream of zero frames.
      send_frame(8'h55, 0, 0, 0, 16, -1, fr);
      model_push(model_entry(8'h55, 0, 0, 0, 0), 0);
      RX = 1'b0;
      repeat (300) @(negedge clk);
      idle(40);
      n_checks++; if (fifo_cnt !== 3'(model_q.size())) $display("FAIL t3_break_cnt: got %0d required %0d", fifo_cnt, model_q.size()); else n_pass++;
      send_frame(8'h3C, 0, 0, 1, 16, -1, fr);
      model_push(model_entry(8'h3C, 0, 0, 0, 1), 0);
      idle(8);
      for (int i = 0; i < 2; i++) begin
         pop_head(d, pe, fe);
         e = model_q.pop_front();
         n_checks++; if ({d, pe, fe} !== {e.data, e.par_err, e.frm_err}) $display("FAIL t3_entry_%0d: got %h/%b/%b required %h/%b/%b", i, d, pe, fe, e.data, e.par_err, e.frm_err); else n_pass++;
      end
   endtask

   task automatic test_overrun();
      int   fr;
      exp_t e;
      logic [DATA_W-1:0] d;
      logic pe, fe;
      for (int i = 1; i <= 5; i++) begin
         send_frame(DATA_W'(i), 0, 0, 1, 16, -1, fr);
         model_push(model_entry(DATA_W'(i), 0, 0, 0, 1), 0);
         idle(8);
      end
      n_checks++; if (fifo_cnt !== 3'(model_q.size())) $display("FAIL t4_cnt: got %0d required %0d", fifo_cnt, model_q.size()); else n_pass++;
      n_checks++; if (overrun !== ovr_exp) $display("FAIL t4_overrun: got %b required %b", overrun, ovr_exp); else n_pass++;
      while (model_q.size() != 0) begin
         pop_head(d, pe, fe);
         e = model_q.pop_front();
         n_checks++; if (d !== e.data) $display("FAIL t4_pop: got %h required %h", d, e.data); else n_pass++;
      end
      clr_ovr = 1'b1;
      @(negedge clk);
      clr_ovr = 1'b0;
      ovr_exp = 1'b0;
      n_checks++; if (overrun !== ovr_exp) $display("FAIL t4_clr_ovr: got %b required %b", overrun, ovr_exp); else n_pass++;
   endtask

   task automatic test_push_pop_full();
      int   fr;
      exp_t e;
      logic [DATA_W-1:0] d, r;
      logic pe, fe;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         r = DATA_W'($urandom);
         send_frame(r, 0, 0, 1, 16, -1, fr);
         model_push(model_entry(r, 0, 0, 0, 1), 0);
         idle(8);
      end
      send_frame(8'h77, 0, 0, 1, 16, push_edge(16, 0), fr);
      model_push(model_entry(8'h77, 0, 0, 0, 1), 1);
      idle(8);
      n_checks++; if (fifo_cnt !== 3'(model_q.size())) $display("FAIL t5_cnt: got %0d required %0d", fifo_cnt, model_q.size()); else n_pass++;
      n_checks++; if (overrun !== ovr_exp) $display("FAIL t5_overrun: got %b required %b", overrun, ovr_exp); else n_pass++;
      while (model_q.size() != 0) begin
         pop_head(d, pe, fe);
         e = model_q.pop_front();
         n_checks++; if (d !== e.data) $display("FAIL t5_pop: got %h required %h", d, e.data); else n_pass++;
      end
   endtask

   task automatic test_random();
      int          fr;
      exp_t        e;
      logic [DATA_W-1:0] d, r;
      logic        pe, fe;
      bit          pen, podd, pbit, stopb;
      int unsigned div;
      for (int n = 0; n < 12; n++) begin
         r = DATA_W'($urandom);
         pen = 1'($urandom); podd = 1'($urandom); pbit = 1'($urandom);
         stopb = ($urandom_range(0, 3) != 0);
         div = $urandom_range(0, 24);
         baud_div = BAUD_W'(div); parity_en = pen; parity_odd = podd;
         send_frame(r, pen, pbit, stopb, eff_div(div), -1, fr);
         model_push(model_entry(r, pen, podd, pbit, stopb), 0);
         idle(12);
         pop_head(d, pe, fe);
         e = model_q.pop_front();
         n_checks++; if ({d, pe, fe} !== {e.data, e.par_err, e.frm_err}) $display("FAIL rand_%0d div=%0d pen=%b odd=%b: got %h/%b/%b required %h/%b/%b", n, div, pen, podd, d, pe, fe, e.data, e.par_err, e.frm_err); else n_pass++;
      end
      baud_div = 16; parity_en = 0; parity_odd = 0;
   endtask

   task automatic test_reconfig();
      int   fr;
      exp_t e;
      logic [DATA_W-1:0] d;
      logic pe, fe;
      baud_div = 16;
      fork
         send_frame(8'h5A, 0, 0, 1, 16, -1, fr);
         begin repeat (40) @(negedge clk); baud_div = 5208; end
      join
      model_push(model_entry(8'h5A, 0, 0, 0, 1), 0);
      idle(8);
      send_frame(8'hC3, 0, 0, 1, 5208, -1, fr);
      model_push(model_entry(8'hC3, 0, 0, 0, 1), 0);
      idle(8);
      for (int i = 0; i < 2; i++) begin
         pop_head(d, pe, fe);
         e = model_q.pop_front();
         n_checks++; if ({d, pe, fe} !== {e.data, e.par_err, e.frm_err}) $display("FAIL t6_reconfig_%0d: got %h/%b/%b required %h/%b/%b", i, d, pe, fe, e.data, e.par_err, e.frm_err); else n_pass++;
      end
      baud_div = 16;
   endtask

   task automatic test_reset_midframe();
      int   fr;
      exp_t e;
      logic [DATA_W-1:0] d;
      logic pe, fe;
      send_frame(8'h11, 0, 0, 1, 16, -1, fr);
      idle(8);
      fork
         send_frame(8'h99, 0, 0, 1, 16, -1, fr);
         begin repeat (70) @(negedge clk); rst_n = 1'b0; end
      join
      model_q.delete();
      ovr_exp = 1'b0;
      n_checks++; if ({rdy, fifo_cnt} !== 4'b0) $display("FAIL t6_rst_flags: got rdy=%b cnt=%0d required 0/0", rdy, fifo_cnt); else n_pass++;
      rst_n = 1'b1;
      idle(40);
      n_checks++; if (fifo_cnt !== 3'(model_q.size())) $display("FAIL t6_rst_stale: got %0d required %0d", fifo_cnt, model_q.size()); else n_pass++;
      send_frame(8'h22, 0, 0, 1, 16, -1, fr);
      model_push(model_entry(8'h22, 0, 0, 0, 1), 0);
      idle(8);
      n_checks++; if (fifo_cnt !== 3'(model_q.size())) $display("FAIL t6_post_cnt: got %0d required %0d", fifo_cnt, model_q.size()); else n_pass++;
      pop_head(d, pe, fe);
      e = model_q.pop_front();
      n_checks++; if ({d, pe, fe} !== {e.data, e.par_err, e.frm_err}) $display("FAIL t6_post_entry: got %h/%b/%b required %h/%b/%b", d, pe, fe, e.data, e.par_err, e.frm_err); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_8n1();
      test_parity();
      test_glitch_framing();
      test_overrun();
      test_push_pop_full();
      test_random();
      test_reconfig();
      test_reset_midframe();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
